// File: rtl/fm_audio_pkg.sv
// Shared types and constants for the FM audio output path.
package fm_audio_pkg;

  localparam int unsigned AUDIO_DATA_W = 32;

  // Channel tag carried alongside each serialized sample.
  localparam logic CHAN_L = 1'b0;
  localparam logic CHAN_R = 1'b1;

  // Pair scheduler states: waiting for a pair, sending left, sending right.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSendL = 2'd1,
    StSendR = 2'd2
  } audio_sched_state_t;

endpackage

// File: rtl/fm_desync_monitor.sv
// Watches the two FIFO empty flags and raises a sticky error once exactly one
// channel has had data for DESYNC_LIMIT consecutive cycles.
module fm_desync_monitor
  import fm_audio_pkg::*;
#(
  parameter int unsigned DESYNC_LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic left_empty_i,
  input  logic right_empty_i,
  input  logic clear_err_i,
  output logic desync_err_o
);

  localparam int unsigned CntW = $clog2(DESYNC_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(DESYNC_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            one_sided;

  assign one_sided = left_empty_i ^ right_empty_i;

  // Saturating run-length of one-sided cycles; clear beats a coincident set.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear_err_i) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else begin
      if (!one_sided) begin
        cnt_d = '0;
      end else if (cnt_q != Limit) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == Limit) begin
        err_d = 1'b1;
      end
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign desync_err_o = err_q;

endmodule

// File: rtl/fm_audio_pair_sched.sv
// Stereo output scheduler: pops the left/right FIFOs only as a matched pair and
// serializes each pair as L then R over a valid/ready stream.
module fm_audio_pair_sched
  import fm_audio_pkg::*;
#(
  parameter int unsigned DATA_W       = AUDIO_DATA_W,
  parameter int unsigned DESYNC_LIMIT = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              left_empty_i,
  input  logic [DATA_W-1:0] left_dout_i,
  output logic              left_rd_en_o,
  input  logic              right_empty_i,
  input  logic [DATA_W-1:0] right_dout_i,
  output logic              right_rd_en_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_chan_o,
  output logic [CNT_W-1:0]  pair_count_o,
  output logic              desync_err_o,
  input  logic              clear_err_i
);

  audio_sched_state_t state_q, state_d;
  logic [DATA_W-1:0]  l_q, l_d;
  logic [DATA_W-1:0]  r_q, r_d;
  logic [CNT_W-1:0]   pair_count_q, pair_count_d;
  logic               can_fetch;
  logic               pop;
  logic               r_accept;

  // A new pair may be fetched when idle or as the held R sample leaves.
  // Gated by reset so a held-in-reset scheduler never drains the FIFOs.
  assign can_fetch = (state_q == StIdle) || ((state_q == StSendR) && out_ready_i);
  assign pop       = reset && enable_i && !left_empty_i && !right_empty_i && can_fetch;
  assign r_accept  = (state_q == StSendR) && out_ready_i;

  assign left_rd_en_o  = pop;
  assign right_rd_en_o = pop;

  // Next-state logic for the L/R serializer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StSendL;
      end
      StSendL: begin
        if (out_ready_i) state_d = StSendR;
      end
      StSendR: begin
        if (out_ready_i) state_d = pop ? StSendL : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture both FIFO heads together on a pop; count completed pairs.
  always_comb begin
    l_d          = l_q;
    r_d          = r_q;
    pair_count_d = pair_count_q;
    if (pop) begin
      l_d = left_dout_i;
      r_d = right_dout_i;
    end
    if (r_accept) begin
      pair_count_d = pair_count_q + 1'b1;
    end
  end

  // State, pair holding and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      l_q          <= '0;
      r_q          <= '0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      l_q          <= l_d;
      r_q          <= r_d;
      pair_count_q <= pair_count_d;
    end
  end

  // Output mux; in idle r_q is the last sample sent, so out_data holds it.
  always_comb begin
    out_valid_o = 1'b0;
    out_chan_o  = CHAN_L;
    out_data_o  = r_q;
    unique case (state_q)
      StSendL: begin
        out_valid_o = 1'b1;
        out_data_o  = l_q;
      end
      StSendR: begin
        out_valid_o = 1'b1;
        out_chan_o  = CHAN_R;
      end
      default: ;
    endcase
  end

  assign pair_count_o = pair_count_q;

  fm_desync_monitor #(
    .DESYNC_LIMIT (DESYNC_LIMIT)
  ) u_desync_monitor (
    .clock         (clock),
    .reset         (reset),
    .left_empty_i  (left_empty_i),
    .right_empty_i (right_empty_i),
    .clear_err_i   (clear_err_i),
    .desync_err_o  (desync_err_o)
  );

endmodule

// File: tb/tb_fm_audio_pair_sched.sv
// Bench for fm_audio_pair_sched: queue-based FIFOs and a transaction-level
// reference model (pending-sample queue, pair tally, one-sided run length).
module tb_fm_audio_pair_sched;

  localparam int unsigned DataW = 32;
  localparam int unsigned Lim   = 4;
  localparam int unsigned CntW  = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable_i = 1'b0;
  logic             left_empty_i = 1'b1;
  logic [DataW-1:0] left_dout_i = '0;
  logic             left_rd_en_o;
  logic             right_empty_i = 1'b1;
  logic [DataW-1:0] right_dout_i = '0;
  logic             right_rd_en_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [DataW-1:0] out_data_o;
  logic             out_chan_o;
  logic [CntW-1:0]  pair_count_o;
  logic             desync_err_o;
  logic             clear_err_i = 1'b0;

  fm_audio_pair_sched #(
    .DATA_W       (DataW),
    .DESYNC_LIMIT (Lim),
    .CNT_W        (CntW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_i      (enable_i),
    .left_empty_i  (left_empty_i),
    .left_dout_i   (left_dout_i),
    .left_rd_en_o  (left_rd_en_o),
    .right_empty_i (right_empty_i),
    .right_dout_i  (right_dout_i),
    .right_rd_en_o (right_rd_en_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_chan_o    (out_chan_o),
    .pair_count_o  (pair_count_o),
    .desync_err_o  (desync_err_o),
    .clear_err_i   (clear_err_i)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic             chan;
  } samp_t;

  logic [DataW-1:0] lq[$];
  logic [DataW-1:0] rq[$];
  samp_t            exp_q[$];
  int unsigned      pairs;
  int unsigned      run;
  logic             flag;
  logic [DataW-1:0] last_out;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pairs    = 0;
    run      = 0;
    flag     = 1'b0;
    last_out = '0;
  endtask

  task automatic drive_fifos();
    left_empty_i  = (lq.size() == 0);
    right_empty_i = (rq.size() == 0);
    left_dout_i   = (lq.size() == 0) ? '0 : lq[0];
    right_dout_i  = (rq.size() == 0) ? '0 : rq[0];
  endtask

  // One clock cycle: drive at the falling edge, check, then apply the edge to the model.
  task automatic run_cycle(input logic en, input logic rdy, input logic clr);
    logic le, re, pred_pop, acc;
    enable_i    = en;
    out_ready_i = rdy;
    clear_err_i = clr;
    drive_fifos();
    le = left_empty_i;
    re = right_empty_i;
    #1;
    pred_pop = en && !le && !re && ((exp_q.size() == 0) || ((exp_q.size() == 1) && rdy));
    check_eq("left_rd_en", 64'(left_rd_en_o), 64'(pred_pop));
    check_eq("right_rd_en", 64'(right_rd_en_o), 64'(pred_pop));
    check_eq("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("out_data", 64'(out_data_o), 64'(exp_q[0].data));
      check_eq("out_chan", 64'(out_chan_o), 64'(exp_q[0].chan));
    end else begin
      check_eq("idle_data", 64'(out_data_o), 64'(last_out));
      check_eq("idle_chan", 64'(out_chan_o), 64'd0);
    end
    check_eq("pair_count", 64'(pair_count_o), 64'(pairs % (1 << CntW)));
    check_eq("desync_err", 64'(desync_err_o), 64'(flag));
    @(posedge clock);
    acc = (exp_q.size() != 0) && rdy;
    if (acc) begin
      last_out = exp_q[0].data;
      if (exp_q[0].chan) pairs++;
      void'(exp_q.pop_front());
    end
    if (pred_pop) begin
      exp_q.push_back('{data: lq[0], chan: 1'b0});
      exp_q.push_back('{data: rq[0], chan: 1'b1});
      void'(lq.pop_front());
      void'(rq.pop_front());
    end
    if (clr) begin
      run  = 0;
      flag = 1'b0;
    end else begin
      if (le != re) begin
        if (run < Lim) run++;
      end else begin
        run = 0;
      end
      if (run == Lim) flag = 1'b1;
    end
    @(negedge clock);
  endtask

  initial begin
    int r;
    model_reset();
    enable_i = 1'b1;
    #1;
    check_eq("rst_valid", 64'(out_valid_o), 64'd0);
    check_eq("rst_data", 64'(out_data_o), 64'd0);
    check_eq("rst_chan", 64'(out_chan_o), 64'd0);
    check_eq("rst_pairs", 64'(pair_count_o), 64'd0);
    check_eq("rst_err", 64'(desync_err_o), 64'd0);
    check_eq("rst_rd_en", 64'(left_rd_en_o | right_rd_en_o), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Back-to-back pairs with a ready sink.
    lq.push_back(32'd100); lq.push_back(-32'sd5);
    rq.push_back(32'd200); rq.push_back(32'sd7);
    repeat (6) run_cycle(1'b1, 1'b1, 1'b0);
    check_eq("t1_pairs", 64'(pair_count_o), 64'd2);

    // Left waits for right.
    lq.push_back(32'd1);
    repeat (10) run_cycle(1'b1, 1'b1, 1'b0);
    check_eq("t2_no_pop", 64'(lq.size()), 64'd1);
    rq.push_back(32'd2);
    repeat (4) run_cycle(1'b1, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1);
    check_eq("t2_cleared", 64'(desync_err_o), 64'd0);

    // Stall during SEND_L.
    lq.push_back(32'h7FFF_FFFF); rq.push_back(32'd3);
    run_cycle(1'b1, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0);
    check_eq("t3_hold_data", 64'(out_data_o), 64'h7FFF_FFFF);
    check_eq("t3_hold_chan", 64'(out_chan_o), 64'd0);
    repeat (3) run_cycle(1'b1, 1'b1, 1'b0);

    // Desync flag set, clear, and clear coinciding with set.
    lq.push_back(32'd9);
    repeat (4) run_cycle(1'b0, 1'b1, 1'b0);
    check_eq("t4_set", 64'(desync_err_o), 64'd1);
    run_cycle(1'b0, 1'b1, 1'b0);
    check_eq("t4_sticky", 64'(desync_err_o), 64'd1);
    run_cycle(1'b0, 1'b1, 1'b1);
    check_eq("t4_clear", 64'(desync_err_o), 64'd0);
    repeat (3) run_cycle(1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1);
    check_eq("t4_clear_wins", 64'(desync_err_o), 64'd0);
    rq.push_back(32'd10);
    repeat (4) run_cycle(1'b1, 1'b1, 1'b0);

    // Enable dropped mid-pair.
    lq.push_back(32'd11); lq.push_back(32'd12);
    rq.push_back(32'd21); rq.push_back(32'd22);
    run_cycle(1'b1, 1'b1, 1'b0);
    repeat (5) run_cycle(1'b0, 1'b1, 1'b0);
    check_eq("t5_left_left", 64'(lq.size()), 64'd1);
    check_eq("t5_right_left", 64'(rq.size()), 64'd1);
    repeat (4) run_cycle(1'b1, 1'b1, 1'b0);

    // Reset during SEND_R.
    lq.push_back(32'd31); lq.push_back(32'd32);
    rq.push_back(32'd41); rq.push_back(32'd42);
    run_cycle(1'b1, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0);
    enable_i    = 1'b1;
    out_ready_i = 1'b0;
    drive_fifos();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("t6_valid", 64'(out_valid_o), 64'd0);
    check_eq("t6_data", 64'(out_data_o), 64'd0);
    check_eq("t6_chan", 64'(out_chan_o), 64'd0);
    check_eq("t6_pairs", 64'(pair_count_o), 64'd0);
    check_eq("t6_rd_en", 64'(left_rd_en_o | right_rd_en_o), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) run_cycle(1'b1, 1'b1, 1'b0);
    check_eq("t6_after_pairs", 64'(pair_count_o), 64'd1);

    // Randomized traffic, including one-sided pushes and pair_count wrap.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35 && lq.size() < 6 && rq.size() < 6) begin
        lq.push_back($urandom());
        rq.push_back($urandom());
      end else if (r < 39 && lq.size() < 6) begin
        lq.push_back($urandom());
      end else if (r < 43 && rq.size() < 6) begin
        rq.push_back($urandom());
      end
      run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 49) == 0);
    end
    repeat (30) run_cycle(1'b1, 1'b1, 1'b0);
    check_eq("final_drained", 64'(exp_q.size()), 64'd0);
    check_eq("final_pairs", 64'(pair_count_o), 64'(pairs % (1 << CntW)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
